fuel_pump_ctrl: RTL and testbench

- Parametrised next-generation fuel pump enable for the anti-theft system.
- Inputs are debounced: ignition, brake, and an N-bit hidden-switch bank.
- Pump power is granted only when a secret switch code is presented with the brake held, inside a timed arming window.
- Once running, power latches until ignition drops; repeated failed attempts cause a timed lockout with an alarm flag.
- Sits between the raw cabin inputs and the pump relay driver.

---
 rtl/fuel_pump_pkg.sv | 24 ++
 rtl/fuel_pump_ctrl_debounce.sv | 52 +++++
 rtl/fuel_pump_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fuel_pump_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuel_pump_pkg.sv
// Shared types and width helpers for the fuel pump anti-theft controller.
package fuel_pump_pkg;

  // Controller state encoding, also driven straight out on the state port.
  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMING  = 2'd1,
    ST_RUN     = 2'd2,
    ST_LOCKOUT = 2'd3
  } fp_state_t;

  localparam int STATE_W    = 2;
  localparam int FAIL_CNT_W = 4;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = 4'hF;

  // Bits needed for a counter that runs from 0 up to max_val-1 (never less than one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val <= 2) begin
      return 1;
    end
    return $clog2(max_val);
  endfunction

endpackage

// File: rtl/fuel_pump_ctrl_debounce.sv
// input_debounce: two-flop synchroniser followed by a stability counter.
// The output takes the synchronised value once it has differed from the
// current output for DEBOUNCE_CYC consecutive cycles, so the raw-to-output
// latency is 2+DEBOUNCE_CYC cycles and shorter glitches never propagate.
module input_debounce
  import fuel_pump_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; adopt the new level once stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      deb <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign dout = deb;

endmodule

// File: rtl/fuel_pump_ctrl.sv
// fuel_pump_ctrl: anti-theft fuel pump enable.
// Debounced ignition, brake and hidden switches drive a four-state FSM that
// only grants pump power when the secret switch code is shown with the brake
// held inside a timed arming window. Repeated failures lock the pump out for
// a while with the alarm raised.
// Optional build macro FUEL_PUMP_PRIME_EN adds a PRIME_CYC-cycle priming pulse
// when arming starts with no failed attempts on record.
module fuel_pump_ctrl
  import fuel_pump_pkg::*;
#(
  parameter int                NUM_SW         = 2,
  parameter logic [NUM_SW-1:0] CODE           = NUM_SW'(2'b10),
  parameter int                DEBOUNCE_CYC   = 16,
  parameter int                ARM_WINDOW_CYC = 1000,
  parameter int                MAX_TRIES      = 3,
  parameter int                LOCKOUT_CYC    = 5000,
  parameter int                PRIME_CYC      = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ignition,
  input  logic                  brake,
  input  logic [NUM_SW-1:0]     hidden_switch,
  output logic                  power,
  output logic                  alarm,
  output logic [STATE_W-1:0]    state,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

`ifdef FUEL_PUMP_PRIME_EN
  localparam bit PRIME_EN = 1'b1;
`else
  localparam bit PRIME_EN = 1'b0;
`endif

  localparam int WIN_W  = cnt_width(ARM_WINDOW_CYC);
  localparam int LOCK_W = cnt_width(LOCKOUT_CYC);
  localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(ARM_WINDOW_CYC - 1);
  localparam logic [LOCK_W-1:0]     LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [FAIL_CNT_W-1:0] TRIES_LIM = FAIL_CNT_W'(MAX_TRIES);

  logic              ign_d;
  logic              brk_d;
  logic [NUM_SW-1:0] sw_d;

  fp_state_t             state_r, state_nxt;
  logic                  power_r, power_nxt;
  logic                  alarm_r, alarm_nxt;
  logic [FAIL_CNT_W-1:0] fail_r, fail_nxt;
  logic [WIN_W-1:0]      win_r, win_nxt;
  logic [LOCK_W-1:0]     lock_r, lock_nxt;
  logic                  prime_ok_r, prime_ok_nxt;
  logic                  brk_prev_r;

  logic                  code_ok;
  logic                  attempt_fail;
  logic [FAIL_CNT_W-1:0] fail_inc;

  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ign (
    .clk  (clk),
    .rst  (rst),
    .din  (ignition),
    .dout (ign_d)
  );

  input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_brk (
    .clk  (clk),
    .rst  (rst),
    .din  (brake),
    .dout (brk_d)
  );

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw_db
    input_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sw (
      .clk  (clk),
      .rst  (rst),
      .din  (hidden_switch[i]),
      .dout (sw_d[i])
    );
  end

  // A failed attempt is a fresh brake press with the wrong code or an expired window.
  assign code_ok      = brk_d && (sw_d == CODE);
  assign attempt_fail = (brk_d && !brk_prev_r && (sw_d != CODE)) || (win_r == WIN_LAST);
  assign fail_inc     = (fail_r == FAIL_CNT_MAX) ? fail_r : fail_r + FAIL_CNT_W'(1);

  // Next-state, counter and registered-output decisions.
  always_comb begin
    state_nxt    = state_r;
    fail_nxt     = fail_r;
    win_nxt      = win_r;
    lock_nxt     = lock_r;
    prime_ok_nxt = prime_ok_r;
    power_nxt    = 1'b0;
    alarm_nxt    = 1'b0;

    case (state_r)
      ST_OFF: begin
        win_nxt      = '0;
        prime_ok_nxt = 1'b0;
        if (ign_d) begin
          state_nxt    = ST_ARMING;
          prime_ok_nxt = PRIME_EN && (fail_r == '0);
        end else begin
          state_nxt = ST_OFF;
        end
      end
      ST_ARMING: begin
        if (!ign_d) begin
          // Tries survive an ignition cycle so it cannot be used to reset them.
          state_nxt    = ST_OFF;
          prime_ok_nxt = 1'b0;
        end else if (code_ok) begin
          state_nxt    = ST_RUN;
          prime_ok_nxt = 1'b0;
        end else if (attempt_fail) begin
          fail_nxt     = fail_inc;
          win_nxt      = '0;
          prime_ok_nxt = 1'b0;
          if (fail_inc == TRIES_LIM) begin
            state_nxt = ST_LOCKOUT;
            lock_nxt  = '0;
          end else begin
            state_nxt = ST_ARMING;
          end
        end else begin
          win_nxt = win_r + WIN_W'(1);
        end
      end
      ST_RUN: begin
        if (!ign_d) begin
          state_nxt = ST_OFF;
          fail_nxt  = '0;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_LOCKOUT: begin
        if (lock_r == LOCK_LAST) begin
          state_nxt = ST_OFF;
          fail_nxt  = '0;
          lock_nxt  = '0;
        end else begin
          lock_nxt = lock_r + LOCK_W'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase

    // Priming covers window counts 1..PRIME_CYC, i.e. starting the cycle after entry.
    if (state_nxt == ST_RUN) begin
      power_nxt = 1'b1;
    end else if (prime_ok_nxt && (state_nxt == ST_ARMING) && (win_nxt != '0)
                 && (int'(win_nxt) <= PRIME_CYC)) begin
      power_nxt = 1'b1;
    end else begin
      power_nxt = 1'b0;
    end

    alarm_nxt = (state_nxt == ST_LOCKOUT);
  end

  // Controller state and output registers; reset drops power immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_OFF;
      power_r    <= 1'b0;
      alarm_r    <= 1'b0;
      fail_r     <= '0;
      win_r      <= '0;
      lock_r     <= '0;
      prime_ok_r <= 1'b0;
      brk_prev_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      power_r    <= power_nxt;
      alarm_r    <= alarm_nxt;
      fail_r     <= fail_nxt;
      win_r      <= win_nxt;
      lock_r     <= lock_nxt;
      prime_ok_r <= prime_ok_nxt;
      brk_prev_r <= brk_d;
    end
  end

  assign power    = power_r;
  assign alarm    = alarm_r;
  assign state    = state_r;
  assign fail_cnt = fail_r;

endmodule

// File: tb/tb_fuel_pump_ctrl.sv
// Self-checking bench for fuel_pump_ctrl with a cycle model of the rules and
// directed scenarios pinned by hand-computed expectations.
module tb_fuel_pump_ctrl;

  localparam int D  = 4;
  localparam int W  = 50;
  localparam int MT = 3;
  localparam int LC = 100;
  localparam int PC = 10;
  localparam logic [1:0] CODE_V = 2'b10;

  localparam int M_OFF  = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_LOCK = 3;

`ifdef FUEL_PUMP_PRIME_EN
  localparam bit PRIME_ON = 1'b1;
`else
  localparam bit PRIME_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ignition = 1'b0;
  logic       brake = 1'b0;
  logic [1:0] hidden_switch = 2'b00;
  logic       power;
  logic       alarm;
  logic [1:0] state;
  logic [3:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  fuel_pump_ctrl #(
    .NUM_SW         (2),
    .CODE           (2'b10),
    .DEBOUNCE_CYC   (D),
    .ARM_WINDOW_CYC (W),
    .MAX_TRIES      (MT),
    .LOCKOUT_CYC    (LC),
    .PRIME_CYC      (PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ignition      (ignition),
    .brake         (brake),
    .hidden_switch (hidden_switch),
    .power         (power),
    .alarm         (alarm),
    .state         (state),
    .fail_cnt      (fail_cnt)
  );

  always #5 clk = ~clk;

  // Model: raw sample history per input (0 ign, 1 brake, 2/3 switches),
  // debounced levels, and the controller's mode, tries and elapsed time.
  typedef struct packed {
    logic [3:0][7:0] h;
    logic [3:0]      deb;
    bit              brk_last;
    int              mode;
    int              tries;
    int              t;
    bit              prime;
  } mdl_t;

  mdl_t m;

  // A debounced level flips when the D synchronised samples (raw from 2..D+1 edges ago) all disagree with it.
  function automatic logic settle(logic cur, logic [7:0] hist);
    for (int k = 1; k <= D; k++) begin
      if (hist[k] == cur) return cur;
    end
    return !cur;
  endfunction

  function automatic mdl_t step(mdl_t x, logic [3:0] raw);
    mdl_t n = x;
    logic ig = x.deb[0];
    logic bk = x.deb[1];
    logic [1:0] sw = x.deb[3:2];
    case (x.mode)
      M_OFF: begin
        if (ig) begin
          n.mode = M_ARM; n.t = 0; n.prime = PRIME_ON && (x.tries == 0);
        end
      end
      M_ARM: begin
        if (!ig) begin
          n.mode = M_OFF; n.prime = 1'b0;
        end else if (bk && sw == CODE_V) begin
          n.mode = M_RUN; n.prime = 1'b0;
        end else if ((bk && !x.brk_last && sw != CODE_V) || x.t == W - 1) begin
          n.tries = (x.tries < 15) ? x.tries + 1 : 15;
          n.t = 0;
          n.prime = 1'b0;
          if (n.tries == MT) n.mode = M_LOCK;
        end else begin
          n.t = x.t + 1;
        end
      end
      M_RUN: begin
        if (!ig) begin
          n.mode = M_OFF; n.tries = 0;
        end
      end
      default: begin
        if (x.t == LC - 1) begin
          n.mode = M_OFF; n.tries = 0; n.t = 0;
        end else begin
          n.t = x.t + 1;
        end
      end
    endcase
    n.brk_last = bk;
    for (int i = 0; i < 4; i++) begin
      n.deb[i] = settle(x.deb[i], x.h[i]);
      n.h[i]   = {x.h[i][6:0], raw[i]};
    end
    return n;
  endfunction

  function automatic int exp_power(mdl_t x);
    if (x.mode == M_RUN) return 1;
    if (x.mode == M_ARM && x.prime && x.t >= 1 && x.t <= PC) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= step(m, {hidden_switch, brake, ignition});
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input int target, input int limit, input string name);
    int k = 0;
    while (int'(state) != target && k < limit) begin
      tick(1);
      k++;
    end
    check(name, int'(state), target);
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("mdl_state", int'(state), m.mode);
      check("mdl_power", int'(power), exp_power(m));
      check("mdl_alarm", int'(alarm), (m.mode == M_LOCK) ? 1 : 0);
      check("mdl_fail",  int'(fail_cnt), m.tries);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_state", int'(state), 0);
    check("rst_power", int'(power), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_fail",  int'(fail_cnt), 0);
    rst = 1'b0;
    tick(2);

    // Glitch rejection: 3-cycle brake pulse with the right code.
    ignition = 1'b1;
    hidden_switch = 2'b10;
    tick(12);
    brake = 1'b1;
    tick(3);
    brake = 1'b0;
    tick(10);
    check("glitch_state", int'(state), 1);
    check("glitch_power", int'(power), 0);
    check("glitch_fail",  int'(fail_cnt), 0);

    // Happy path: power exactly 7 cycles after brake rises.
    brake = 1'b1;
    tick(6);
    check("run_pre_power", int'(power), 0);
    tick(1);
    check("run_power", int'(power), 1);
    check("run_state", int'(state), 2);
    brake = 1'b0;
    tick(20);
    check("run_hold_power", int'(power), 1);
    ignition = 1'b0;
    tick(6);
    check("ignoff_pre_state", int'(state), 2);
    tick(1);
    check("ignoff_state", int'(state), 0);
    check("ignoff_power", int'(power), 0);

    // Wrong code: three presses lead to lockout.
    hidden_switch = 2'b01;
    ignition = 1'b1;
    tick(12);
    for (int p = 1; p <= 2; p++) begin
      brake = 1'b1;
      tick(8);
      check("wrong_fail", int'(fail_cnt), p);
      check("wrong_state", int'(state), 1);
      brake = 1'b0;
      tick(8);
    end
    brake = 1'b1;
    wait_state(3, 20, "lock_enter");
    check("lock_alarm", int'(alarm), 1);
    check("lock_fail",  int'(fail_cnt), 3);
    ignition = 1'b0;
    brake = 1'b0;
    tick(99);
    check("lock_end_state", int'(state), 3);
    check("lock_end_alarm", int'(alarm), 1);
    tick(1);
    check("unlock_state", int'(state), 0);
    check("unlock_alarm", int'(alarm), 0);
    check("unlock_fail",  int'(fail_cnt), 0);

    // Window timeout, tries survive an ignition cycle.
    ignition = 1'b1;
    wait_state(1, 20, "win_enter");
    tick(49);
    check("win_pre_fail", int'(fail_cnt), 0);
    tick(1);
    check("win_fail",  int'(fail_cnt), 1);
    check("win_state", int'(state), 1);
    ignition = 1'b0;
    tick(10);
    check("cycle_off_state", int'(state), 0);
    check("cycle_off_fail",  int'(fail_cnt), 1);
    ignition = 1'b1;
    tick(10);
    check("cycle_on_state", int'(state), 1);
    check("cycle_on_fail",  int'(fail_cnt), 1);

    // Asynchronous reset while running.
    hidden_switch = 2'b10;
    brake = 1'b1;
    wait_state(2, 20, "rst_run_enter");
    check("rst_run_power", int'(power), 1);
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check("async_power", int'(power), 0);
    check("async_state", int'(state), 0);
    ignition = 1'b0;
    brake = 1'b0;
    hidden_switch = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("post_rst_state", int'(state), 0);
    check("post_rst_fail",  int'(fail_cnt), 0);

    // Priming on arming entry (power stays off without the feature).
    ignition = 1'b1;
    tick(6);
    check("prime_pre_state", int'(state), 0);
    tick(1);
    check("prime_entry_state", int'(state), 1);
    check("prime_entry_power", int'(power), 0);
    for (int k = 1; k <= PC; k++) begin
      tick(1);
      check("prime_power", int'(power), PRIME_ON ? 1 : 0);
    end
    tick(1);
    check("prime_end_power", int'(power), 0);
    check("prime_end_state", int'(state), 1);

    // Success in the middle of priming keeps power continuous into RUN.
    ignition = 1'b0;
    hidden_switch = 2'b10;
    tick(10);
    check("prime2_off_state", int'(state), 0);
    ignition = 1'b1;
    tick(5);
    brake = 1'b1;
    tick(1);
    check("prime2_pre_state", int'(state), 0);
    tick(1);
    check("prime2_entry_state", int'(state), 1);
    check("prime2_entry_power", int'(power), 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("prime2_power", int'(power), PRIME_ON ? 1 : 0);
      check("prime2_state", int'(state), 1);
    end
    tick(1);
    check("prime2_run_state", int'(state), 2);
    check("prime2_run_power", int'(power), 1);
    tick(3);
    check("prime2_hold_power", int'(power), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
